// File: rtl/dot_product_accumulator_if.sv
// dot_product_accumulator_if
//   Groups the multiplier-side inputs and the result outputs of
//   dot_product_accumulator into one bundle.
//   Parameter ACC_W must match the ACC_W of the attached accumulator.
//   Signals:
//     in_valid, in_last : operand-side tags (driven by the producer)
//     p                 : 8-bit multiplier product
//     sum, sum_valid,
//     term_count, ovf   : per-vector result (driven by the accumulator)
//     busy              : work in flight or partial vector held
//   Modports: master (producer / consumer of results), slave (accumulator).
interface dot_product_accumulator_if #(
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_last;
    logic [7:0]       p;
    logic [ACC_W-1:0] sum;
    logic             sum_valid;
    logic [7:0]       term_count;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, in_last, p,
        input  sum, sum_valid, term_count, ovf, busy
    );

    modport slave (
        input  in_valid, in_last, p,
        output sum, sum_valid, term_count, ovf, busy
    );
endinterface

// File: rtl/dot_product_accumulator.sv
// dot_product_accumulator
//   Sums the valid 8-bit products of a pipelined multiplier into one
//   dot-product result per vector. A shadow pipeline of {valid, last}
//   delays the operand-side tags by MUL_LAT cycles so they line up with p.
//   Parameters: MUL_LAT (multiplier latency), ACC_W (8..32).
//   Ports:
//     clk : rising-edge clock
//     rst : synchronous active-high reset
//     bus : dot_product_accumulator_if.slave (in_valid, in_last, p in;
//           sum, sum_valid, term_count, ovf, busy out)
//   Build option: define SATURATE_EN to clamp the accumulator at
//   2^ACC_W-1 on carry out instead of wrapping modulo 2^ACC_W.
module dot_product_accumulator #(
    parameter int MUL_LAT = 5,
    parameter int ACC_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    dot_product_accumulator_if.slave   bus
);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t             state, state_n;
    logic [MUL_LAT-1:0] sh_v, sh_l;
    logic               tv, tl;

    logic [ACC_W-1:0]   acc, acc_n;
    logic [7:0]         cnt, cnt_n;
    logic               ovf_r, ovf_r_n;
    logic [ACC_W-1:0]   sum_r, sum_n;
    logic [7:0]         tc_r, tc_n;
    logic               ovf_o, ovf_o_n;
    logic               sv_r, sv_n;

    logic [ACC_W-1:0]   p_ext;
    logic [ACC_W:0]     add_full;
    logic               carry;
    logic [ACC_W-1:0]   add_res;
    logic [7:0]         cnt_inc;

    assign tv = sh_v[MUL_LAT-1];
    assign tl = sh_l[MUL_LAT-1];

    always_comb begin
        p_ext    = ACC_W'(p_in());
        add_full = {1'b0, acc} + {1'b0, p_ext};
        carry    = add_full[ACC_W];
`ifdef SATURATE_EN
        add_res  = carry ? '1 : add_full[ACC_W-1:0];
`else
        add_res  = add_full[ACC_W-1:0];
`endif
        cnt_inc  = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end

    function automatic logic [7:0] p_in();
        return bus.p;
    endfunction

    // Next-state and datapath decode
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        ovf_r_n = ovf_r;
        sum_n   = sum_r;
        tc_n    = tc_r;
        ovf_o_n = ovf_o;
        sv_n    = 1'b0;
        case (state)
            IDLE: begin
                if (tv) begin
                    if (tl) begin
                        sum_n   = p_ext;
                        tc_n    = 8'd1;
                        ovf_o_n = 1'b0;
                        sv_n    = 1'b1;
                    end else begin
                        acc_n   = p_ext;
                        cnt_n   = 8'd1;
                        ovf_r_n = 1'b0;
                        state_n = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (tv) begin
                    acc_n   = add_res;
                    cnt_n   = cnt_inc;
                    ovf_r_n = ovf_r | carry;
                    if (tl) begin
                        sum_n   = add_res;
                        tc_n    = cnt_inc;
                        ovf_o_n = ovf_r | carry;
                        sv_n    = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_v  <= '0;
            sh_l  <= '0;
            acc   <= '0;
            cnt   <= '0;
            ovf_r <= 1'b0;
            sum_r <= '0;
            tc_r  <= '0;
            ovf_o <= 1'b0;
            sv_r  <= 1'b0;
        end else begin
            sh_v[0] <= bus.in_valid;
            sh_l[0] <= bus.in_valid & bus.in_last;
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                sh_v[i] <= sh_v[i-1];
                sh_l[i] <= sh_l[i-1];
            end
            acc   <= acc_n;
            cnt   <= cnt_n;
            ovf_r <= ovf_r_n;
            sum_r <= sum_n;
            tc_r  <= tc_n;
            ovf_o <= ovf_o_n;
            sv_r  <= sv_n;
        end
    end

    assign bus.sum        = sum_r;
    assign bus.sum_valid  = sv_r;
    assign bus.term_count = tc_r;
    assign bus.ovf        = ovf_o;
    assign bus.busy       = (|sh_v) | (state == ACCUM);

endmodule

// File: tb/tb_dot_product_accumulator.sv
module tb_dot_product_accumulator;

    localparam int MUL_LAT = 5;
`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_last;
    logic [3:0] a, b;
    int         cyc = 0;
    int         tests_run = 0;
    int         tests_failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural stand-in for the 4x4 multiplier: product of operands
    // presented in cycle t appears on p during cycle t+MUL_LAT. Not reset.
    logic [7:0] mpipe [MUL_LAT];
    always @(posedge clk) begin
        mpipe[0] <= {4'd0, a} * {4'd0, b};
        for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
    end

    dot_product_accumulator_if #(.ACC_W(16)) bus16();
    dot_product_accumulator_if #(.ACC_W(8))  bus8();

    assign bus16.in_valid = in_valid;
    assign bus16.in_last  = in_last;
    assign bus16.p        = mpipe[MUL_LAT-1];
    assign bus8.in_valid  = in_valid;
    assign bus8.in_last   = in_last;
    assign bus8.p         = mpipe[MUL_LAT-1];

    dot_product_accumulator #(.MUL_LAT(MUL_LAT), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .bus(bus16)
    );
    dot_product_accumulator #(.MUL_LAT(MUL_LAT), .ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8)
    );

    typedef struct {
        int          cyc;
        logic [7:0]  cnt;
        logic [15:0] s16;
        logic        o16;
        logic [7:0]  s8;
        logic        o8;
    } exp_t;

    exp_t q[$];

    // Scoreboard monitor: each expected result must appear exactly in its cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            tests_run++;
            if (bus16.sum_valid !== 1'b1 || bus8.sum_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL pulse@%0d: sum_valid16=%b sum_valid8=%b, required 1", cyc, bus16.sum_valid, bus8.sum_valid);
            end
            tests_run++;
            if (bus16.sum !== e.s16 || bus16.ovf !== e.o16) begin
                tests_failed++;
                $display("FAIL sum16@%0d: sum=%0d ovf=%b, required sum=%0d ovf=%b", cyc, bus16.sum, bus16.ovf, e.s16, e.o16);
            end
            tests_run++;
            if (bus8.sum !== e.s8 || bus8.ovf !== e.o8) begin
                tests_failed++;
                $display("FAIL sum8@%0d: sum=%0d ovf=%b, required sum=%0d ovf=%b", cyc, bus8.sum, bus8.ovf, e.s8, e.o8);
            end
            tests_run++;
            if (bus16.term_count !== e.cnt || bus8.term_count !== e.cnt) begin
                tests_failed++;
                $display("FAIL term_count@%0d: cnt16=%0d cnt8=%0d, required %0d", cyc, bus16.term_count, bus8.term_count, e.cnt);
            end
        end else if (bus16.sum_valid !== 1'b0 || bus8.sum_valid !== 1'b0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL stray_pulse@%0d: sum_valid16=%b sum_valid8=%b, required 0", cyc, bus16.sum_valid, bus8.sum_valid);
        end
    end

    task automatic drive(input logic v, input logic l, input logic [3:0] aa, input logic [3:0] bb);
        in_valid = v;
        in_last  = l;
        a        = aa;
        b        = bb;
        @(posedge clk);
        #1;
    endtask

    // Called in the cycle the last term is presented
    task automatic expect_res(input logic [7:0] cnt, input logic [15:0] s16, input logic o16,
                              input logic [7:0] s8, input logic o8);
        exp_t e;
        e.cyc = cyc + MUL_LAT + 1;
        e.cnt = cnt;
        e.s16 = s16;
        e.o16 = o16;
        e.s8  = s8;
        e.o8  = o8;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() > 0 && n < 40) begin
            drive(1'b0, 1'b0, 4'd0, 4'd0);
            n++;
        end
        repeat (3) drive(1'b0, 1'b0, 4'd0, 4'd0);
        tests_run++;
        if (q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_timeout: %0d results outstanding, required 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        rst = 1'b0;
        tests_run++;
        if (bus16.sum !== 16'd0 || bus16.term_count !== 8'd0 || bus16.ovf !== 1'b0 ||
            bus16.sum_valid !== 1'b0 || bus16.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset16: sum=%0d cnt=%0d ovf=%b sv=%b busy=%b, required all 0",
                     bus16.sum, bus16.term_count, bus16.ovf, bus16.sum_valid, bus16.busy);
        end
        tests_run++;
        if (bus8.sum !== 8'd0 || bus8.term_count !== 8'd0 || bus8.ovf !== 1'b0 ||
            bus8.sum_valid !== 1'b0 || bus8.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset8: sum=%0d cnt=%0d ovf=%b sv=%b busy=%b, required all 0",
                     bus8.sum, bus8.term_count, bus8.ovf, bus8.sum_valid, bus8.busy);
        end
    endtask

    task automatic test_vector();
        drive(1'b1, 1'b0, 4'd3, 4'd5);
        tests_run++;
        if (bus16.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL vector_busy: busy=%b, required 1", bus16.busy);
        end
        drive(1'b1, 1'b0, 4'd2, 4'd7);
        expect_res(8'd3, 16'd254, 1'b0, 8'd254, 1'b0);
        drive(1'b1, 1'b1, 4'd15, 4'd15);
        drain("vector");
        tests_run++;
        if (bus16.sum !== 16'd254 || bus16.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL vector_hold: sum=%0d busy=%b, required sum=254 busy=0", bus16.sum, bus16.busy);
        end
    endtask

    task automatic test_single();
        expect_res(8'd1, 16'd225, 1'b0, 8'd225, 1'b0);
        drive(1'b1, 1'b1, 4'd15, 4'd15);
        drain("single");
    endtask

    task automatic test_overflow();
        drive(1'b1, 1'b0, 4'd15, 4'd15);
        expect_res(8'd2, 16'd450, 1'b0, SAT ? 8'd255 : 8'd194, 1'b1);
        drive(1'b1, 1'b1, 4'd15, 4'd15);
        expect_res(8'd1, 16'd1, 1'b0, 8'd1, 1'b0);
        drive(1'b1, 1'b1, 4'd1, 4'd1);
        drain("overflow");
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 4'd1, 4'd2);
        expect_res(8'd2, 16'd14, 1'b0, 8'd14, 1'b0);
        drive(1'b1, 1'b1, 4'd3, 4'd4);
        expect_res(8'd1, 16'd30, 1'b0, 8'd30, 1'b0);
        drive(1'b1, 1'b1, 4'd5, 4'd6);
        drain("back_to_back");
    endtask

    task automatic test_bubbles();
        drive(1'b1, 1'b0, 4'd2, 4'd2);
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        drive(1'b0, 1'b1, 4'd9, 4'd9);
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        expect_res(8'd2, 16'd20, 1'b0, 8'd20, 1'b0);
        drive(1'b1, 1'b1, 4'd4, 4'd4);
        drain("bubbles");
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 4'd7, 4'd7);
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        rst = 1'b0;
        tests_run++;
        if (bus16.busy !== 1'b0 || bus8.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_busy: busy16=%b busy8=%b, required 0", bus16.busy, bus8.busy);
        end
        drive(1'b0, 1'b0, 4'd0, 4'd0);
        expect_res(8'd1, 16'd3, 1'b0, 8'd3, 1'b0);
        drive(1'b1, 1'b1, 4'd1, 4'd3);
        drain("reset_mid");
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 255; i++) drive(1'b1, 1'b0, 4'd1, 4'd1);
        expect_res(8'd255, 16'd256, 1'b0, SAT ? 8'd255 : 8'd0, 1'b1);
        drive(1'b1, 1'b1, 4'd1, 4'd1);
        drain("count_sat");
        tests_run++;
        if (bus16.term_count !== 8'd255 || bus16.sum !== 16'd256) begin
            tests_failed++;
            $display("FAIL count_sat_hold: cnt=%0d sum=%0d, required cnt=255 sum=256", bus16.term_count, bus16.sum);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        a        = 4'd0;
        b        = 4'd0;
        repeat (MUL_LAT + 1) @(posedge clk);
        #1;
        test_reset();
        test_vector();
        test_single();
        test_overflow();
        test_back_to_back();
        test_bubbles();
        test_reset_mid();
        test_count_sat();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/dot_product_accumulator.md
# dot_product_accumulator

Downstream consumer of the 4x4 pipelined array multiplier. It tracks which multiplier products are valid by delaying the operand-side valid/last flags through a shadow pipeline matched to the multiplier latency. It sums the valid 8-bit products of each vector into an accumulator and emits one dot-product result per vector, with a term count and an overflow flag.

## Interface
- MUL_LAT, 5: multiplier latency in cycles, from operands presented to the product being stable on `p`.
- ACC_W, 16: accumulator and result width; legal range 8..32.
- clk  input  1  rising-edge clock, shared with the multiplier.
- rst  input  1  reset; one clock; synchronous, active-high.
- in_valid  input  1  operand pair a/b is presented to the multiplier this cycle.
- in_last  input  1  this operand pair is the final term of the vector; only meaningful when in_valid=1.
- p  input  8  multiplier product output.
- sum  output  ACC_W  dot-product result; held until the next result.
- sum_valid  output  1  one-cycle pulse; sum, term_count and ovf are valid.
- term_count  output  8  number of terms in the reported vector; saturates at 255.
- ovf  output  1  accumulation overflowed ACC_W bits at any point in the reported vector.
- busy  output  1  a tagged term is in flight, or a vector is partially accumulated.

## Operation
- Shadow pipeline: MUL_LAT-stage shift register of {valid, last}.
  - Stage 0 loads {in_valid, in_valid&in_last}.
  - The tap at stage MUL_LAT-1 is tv/tl. It is aligned with `p` for the matching operands.
- FSM states:
  - IDLE: no partial sum.
  - ACCUM: partial sum held in acc.
- IDLE with tv=1, tl=0: acc<=p, cnt<=1, ovf_r<=0, go to ACCUM.
- IDLE with tv=1, tl=1: single-term vector. sum<=p, term_count<=1, ovf<=0, sum_valid<=1, stay IDLE.
- ACCUM with tv=1: acc<=acc+p, cnt<=cnt+1 (saturating at 255), ovf_r |= carry out of ACC_W.
  - If tl=1: sum<=acc+p, term_count<=cnt+1 (saturating), ovf<=ovf_r|carry, sum_valid<=1, go to IDLE.
- tv=0: no state change; bubbles are allowed anywhere in a vector.
- in_last with in_valid=0 is ignored.
- Arithmetic: p is zero-extended to ACC_W. Carry out of ACC_W is wrapped or saturated per Configuration.
- Back-to-back vectors: a last term followed by the next vector's first term on the next tagged cycle needs no gap. Both results are reported.
- busy = OR of all shadow stages | (state==ACCUM).
- Reset:
  - Clears the shadow pipeline, acc, cnt and ovf_r; FSM goes to IDLE.
  - Products of operands issued before reset are discarded, even though they still emerge from the multiplier.
  - Reset mid-vector produces no sum_valid for that vector.

## Timing
- Reset values: sum=0, sum_valid=0, term_count=0, ovf=0, busy=0.
- Operand cycle t (in_valid=1): product consumed in cycle t+MUL_LAT.
- For a last term issued in cycle t, sum_valid is high in cycle t+MUL_LAT+1, for exactly one cycle.
- Latency from the last term's operands to result: MUL_LAT+1 cycles.
- Throughput: one term per cycle, sustained across vectors.
- sum, term_count and ovf are registered and stable from the sum_valid cycle until the next sum_valid.

## Configuration
- SATURATE_EN defined:
  - On carry out, acc (and sum) clamp to 2^ACC_W-1 and stay clamped for the rest of the vector.
  - ovf still sets.
- SATURATE_EN undefined: modulo-2^ACC_W wrap; ovf sets on carry.

## Test plan
- Vector (3,5),(2,7),(15,15), issued in cycles 0,1,2 with in_last on the third:
  - sum_valid in cycle 8 only.
  - sum=254, term_count=3, ovf=0.
- Single term (15,15) with in_last in cycle 0: sum=225, term_count=1, sum_valid in cycle 6.
- ACC_W=8, terms (15,15),(15,15):
  - Without SATURATE_EN: sum=194, ovf=1.
  - With SATURATE_EN: sum=255, ovf=1.
  - Next vector (1,1) last: sum=1, ovf=0.
- Back-to-back vectors [(1,2),(3,4) last] then [(5,6) last] in cycles 0-2:
  - Pulses in cycle 7 (sum=14, cnt=2) and cycle 8 (sum=30, cnt=1).
- Bubbles and stray last:
  - Term (2,2) in cycle 0, gap, in_last with in_valid=0 in cycle 2, (4,4) last in cycle 4.
  - Single pulse in cycle 10: sum=20, term_count=2.
- Reset mid-vector: (7,7) in cycle 0, rst in cycle 2, then (1,3) last in cycle 4:
  - Only pulse is in cycle 10: sum=3, term_count=1.
  - busy=0 in the cycle after rst.
